// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle instruction sequencer for a tiny 32-bit ISA.
// Each instruction passes through FETCH, DECODE and EXECUTE. ALU instructions
// also take a WRITEBACK cycle. The program counter is 5 bits wide, so it
// addresses a 32-word instruction memory.
// The instruction memory and the register file are external and combinational.
// All outputs are driven straight from registers.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  imem_addr,
    input  logic [31:0] imem_instr,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        rf_we,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    // Opcode map
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd4;
    localparam logic [5:0] OP_OR   = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd6;
    localparam logic [5:0] OP_SUBI = 6'd7;
    localparam logic [5:0] OP_BEQ  = 6'd8;
    localparam logic [5:0] OP_J    = 6'd9;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    // Instruction classes. Each class selects its own EXECUTE behaviour.
    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_ALU_R   = 3'd1,
        CL_ALU_I   = 3'd2,
        CL_BEQ     = 3'd3,
        CL_J       = 3'd4,
        CL_HALT    = 3'd5,
        CL_ILLEGAL = 3'd6
    } iclass_t;

    // Maps an opcode to its instruction class. Unlisted opcodes are illegal.
    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t cl;
        case (op)
            OP_NOP:                         cl = CL_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  cl = CL_ALU_R;
            OP_ADDI, OP_SUBI:               cl = CL_ALU_I;
            OP_BEQ:                         cl = CL_BEQ;
            OP_J:                           cl = CL_J;
            OP_HALT:                        cl = CL_HALT;
            default:                        cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

    // ALU. Arithmetic is modulo 2^32 and carries or borrows are discarded.
    // The immediate is zero-extended.
    function automatic logic [31:0] alu_eval(input logic [5:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [15:0] imm);
        logic [31:0] res;
        logic [31:0] imm_ext;
        imm_ext = {16'd0, imm};
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADDI: res = a + imm_ext;
            OP_SUBI: res = a - imm_ext;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    state_t       state_r;
    state_t       next_state_s;

    logic [4:0]   pc_r;
    logic [31:0]  ir_r;
    logic [31:0]  a_r;
    logic [31:0]  b_r;
    logic [31:0]  result_r;
    logic [15:0]  instr_count_r;
    logic         illegal_r;
    logic [4:0]   rf_ra1_r;
    logic [4:0]   rf_ra2_r;
    logic [4:0]   rf_wa_r;
    logic         rf_we_r;
    logic         busy_r;
    logic         halted_r;

    // Decoded view of the instruction register
    logic [5:0]   op_s;
    logic [4:0]   rt_s;
    logic [4:0]   rd_s;
    logic [15:0]  imm_s;
    logic [4:0]   jump_pc_s;
    iclass_t      iclass_s;
    logic [31:0]  alu_out_s;
    logic [4:0]   dest_s;
    logic [4:0]   pc_seq_s;
    logic [4:0]   pc_next_s;

    // Next-cycle values of the registered status outputs
    logic         busy_s;
    logic         halted_s;
    logic         rf_we_s;

    assign op_s      = ir_r[31:26];
    assign rt_s      = ir_r[20:16];
    assign rd_s      = ir_r[15:11];
    assign imm_s     = ir_r[15:0];
    assign jump_pc_s = ir_r[4:0];
    assign iclass_s  = classify(op_s);
    assign alu_out_s = alu_eval(op_s, a_r, b_r, imm_s);
    assign pc_seq_s  = pc_r + 5'd1;

    // Selects the destination register. R-type writes rd and I-type writes rt.
    always_comb begin
        dest_s = rd_s;
        if (iclass_s == CL_ALU_I) begin
            dest_s = rt_s;
        end else begin
            dest_s = rd_s;
        end
    end

    // Computes the next pc. All results wrap modulo 32.
    always_comb begin
        pc_next_s = pc_seq_s;
        case (iclass_s)
            CL_BEQ: begin
                if (a_r == b_r) begin
                    pc_next_s = pc_seq_s + imm_s[4:0];
                end else begin
                    pc_next_s = pc_seq_s;
                end
            end
            CL_J:    pc_next_s = jump_pc_s;
            default: pc_next_s = pc_seq_s;
        endcase
    end

    // State register. Reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. start is honoured only in IDLE and HALT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_FETCH:     next_state_s = ST_DECODE;
            ST_DECODE:    next_state_s = ST_EXECUTE;
            ST_EXECUTE: begin
                case (iclass_s)
                    CL_ALU_R, CL_ALU_I:   next_state_s = ST_WRITEBACK;
                    CL_NOP, CL_BEQ, CL_J: next_state_s = ST_FETCH;
                    default:              next_state_s = ST_HALT;
                endcase
            end
            ST_WRITEBACK: next_state_s = ST_FETCH;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // Output decode. Computes the values the status registers take next cycle.
    always_comb begin
        busy_s   = 1'b0;
        halted_s = 1'b0;
        rf_we_s  = 1'b0;
        case (next_state_s)
            ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK: busy_s = 1'b1;
            ST_HALT:                                       halted_s = 1'b1;
            default: begin
                busy_s   = 1'b0;
                halted_s = 1'b0;
            end
        endcase
        if ((state_r == ST_EXECUTE) &&
            ((iclass_s == CL_ALU_R) || (iclass_s == CL_ALU_I)) &&
            (dest_s != 5'd0)) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Status output registers. The write enable is high only in WRITEBACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            rf_we_r  <= 1'b0;
        end else begin
            busy_r   <= busy_s;
            halted_r <= halted_s;
            rf_we_r  <= rf_we_s;
        end
    end

    // Datapath: pc, IR, operands, result, retire counter and the illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= 5'd0;
            ir_r          <= 32'd0;
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            result_r      <= 32'd0;
            instr_count_r <= 16'd0;
            illegal_r     <= 1'b0;
            rf_ra1_r      <= 5'd0;
            rf_ra2_r      <= 5'd0;
            rf_wa_r       <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc_r          <= 5'd0;
                        instr_count_r <= 16'd0;
                        illegal_r     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // The read addresses are loaded here, so they are stable
                    // for the whole DECODE cycle.
                    ir_r     <= imem_instr;
                    rf_ra1_r <= imem_instr[25:21];
                    rf_ra2_r <= imem_instr[20:16];
                end
                ST_DECODE: begin
                    a_r <= rf_rd1;
                    b_r <= rf_rd2;
                end
                ST_EXECUTE: begin
                    case (iclass_s)
                        CL_ALU_R, CL_ALU_I: begin
                            result_r <= alu_out_s;
                            rf_wa_r  <= dest_s;
                            pc_r     <= pc_next_s;
                        end
                        CL_NOP, CL_BEQ, CL_J: begin
                            pc_r          <= pc_next_s;
                            instr_count_r <= instr_count_r + 16'd1;
                        end
                        CL_HALT: begin
                            instr_count_r <= instr_count_r + 16'd1;
                        end
                        default: begin
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                ST_WRITEBACK: begin
                    instr_count_r <= instr_count_r + 16'd1;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign rf_ra1      = rf_ra1_r;
    assign rf_ra2      = rf_ra2_r;
    assign rf_wa       = rf_wa_r;
    assign rf_wd       = result_r;
    assign rf_we       = rf_we_r;
    assign busy        = busy_r;
    assign halted      = halted_r;
    assign illegal     = illegal_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. The bench supplies the instruction memory and
// the register file. An instruction-level reference interpreter predicts the
// fetch address, the write-back and the retire count of every instruction,
// cycle by cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    logic [31:0] mem [32];
    logic [31:0] rf  [32];
    logic [31:0] mrf [32];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] W_HALT = {6'd63, 26'd0};

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .rf_we       (rf_we),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];
    assign rf_rd1     = rf[rf_ra1];
    assign rf_rd2     = rf[rf_ra2];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'd0;
            rf[i]  = 32'd0;
        end
    endtask

    // Reference interpreter. It executes one instruction against mrf.
    task automatic model_step(input logic [4:0] pc, output int lat, output bit we,
                              output logic [4:0] wa, output logic [31:0] wd,
                              output logic [4:0] npc, output bit stop, output bit ill);
        logic [31:0] w;
        logic [5:0]  op;
        logic [31:0] va, vb, imm;
        w   = mem[pc];
        op  = w[31:26];
        va  = mrf[w[25:21]];
        vb  = mrf[w[20:16]];
        imm = {16'd0, w[15:0]};
        lat = 3; we = 1'b0; wa = 5'd0; wd = 32'd0; npc = pc + 5'd1; stop = 1'b0; ill = 1'b0;
        case (op)
            6'd0: ;
            6'd2: begin lat = 4; wa = w[15:11]; wd = va + vb;  end
            6'd3: begin lat = 4; wa = w[15:11]; wd = va - vb;  end
            6'd4: begin lat = 4; wa = w[15:11]; wd = va & vb;  end
            6'd5: begin lat = 4; wa = w[15:11]; wd = va | vb;  end
            6'd6: begin lat = 4; wa = w[20:16]; wd = va + imm; end
            6'd7: begin lat = 4; wa = w[20:16]; wd = va - imm; end
            6'd8: if (va == vb) npc = pc + 5'd1 + w[4:0];
            6'd9: npc = w[4:0];
            6'd63: begin stop = 1'b1; npc = pc; end
            default: begin stop = 1'b1; ill = 1'b1; npc = pc; end
        endcase
        if (lat == 4 && wa != 5'd0) begin
            we = 1'b1;
            mrf[wa] = wd;
        end
    endtask

    // Starts a program and checks every cycle against the model. The model
    // runs until it halts or has covered max_instr instructions. When hammer
    // is set, start stays high during the whole run.
    task automatic run_prog(input int max_instr, input bit hammer);
        logic [4:0]  pc, npc, wa;
        logic [15:0] cnt;
        logic [31:0] wd;
        int          lat;
        bit          we, stop, ill, eill;
        pc = 5'd0; cnt = 16'd0; eill = 1'b0; stop = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = rf[i];
        @(negedge clk) start = 1'b1;
        @(negedge clk) if (!hammer) start = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            model_step(pc, lat, we, wa, wd, npc, stop, ill);
            for (int k = 0; k < lat; k++) begin
                if (k > 0) @(negedge clk);
                if (k == 0) begin
                    chk("fetch_addr", {27'd0, imem_addr}, {27'd0, pc});
                    chk("count_at_fetch", {16'd0, instr_count}, {16'd0, cnt});
                    chk("illegal_running", {31'd0, illegal}, 32'd0);
                end
                chk("busy", {31'd0, busy}, 32'd1);
                chk("rf_we", {31'd0, rf_we}, {31'd0, (k == 3) && we});
                if (k == 3 && we) begin
                    chk("rf_wa", {27'd0, rf_wa}, {27'd0, wa});
                    chk("rf_wd", rf_wd, wd);
                end
                if (rf_we) rf[rf_wa] = rf_wd;
            end
            if (!ill) cnt = cnt + 16'd1;
            if (ill) eill = 1'b1;
            @(negedge clk);
            if (stop) break;
            pc = npc;
        end
        start = 1'b0;
        if (stop) begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("busy_halt", {31'd0, busy}, 32'd0);
            chk("illegal_end", {31'd0, illegal}, {31'd0, eill});
            chk("count_end", {16'd0, instr_count}, {16'd0, cnt});
            chk("pc_end", {27'd0, imem_addr}, {27'd0, pc});
            chk("rf_we_halt", {31'd0, rf_we}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},   {27'd0, imem_addr},   32'd0);
        chk({tag, "_we"},     {31'd0, rf_we},       32'd0);
        chk({tag, "_busy"},   {31'd0, busy},        32'd0);
        chk({tag, "_halted"}, {31'd0, halted},      32'd0);
        chk({tag, "_ill"},    {31'd0, illegal},     32'd0);
        chk({tag, "_count"},  {16'd0, instr_count}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0]  legal_ops [9];
        logic [5:0]  op;
        logic [31:0] rnd;
        int          r;
        legal_ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};

        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_addr", {27'd0, imem_addr}, 32'd0);

        // Three writes, then HALT
        mem[0] = enc_i(6'd6, 5'd0, 5'd10, 16'd10);
        mem[1] = enc_i(6'd6, 5'd0, 5'd15, 16'd15);
        mem[2] = enc_r(6'd2, 5'd10, 5'd15, 5'd25);
        mem[3] = W_HALT;
        run_prog(10, 1'b0);
        chk("r25_value", rf[25], 32'd25);
        chk("r10_value", rf[10], 32'd10);

        // The same program with start held high all the way through
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        run_prog(10, 1'b1);
        chk("hammer_r25", rf[25], 32'd25);

        // BEQ taken and not taken
        clear_mem();
        mem[0] = enc_i(6'd6, 5'd0, 5'd4, 16'd4);
        mem[1] = enc_i(6'd6, 5'd0, 5'd5, 16'd4);
        mem[2] = enc_i(6'd8, 5'd4, 5'd5, 16'd7);
        mem[3] = W_HALT;
        mem[10] = W_HALT;
        run_prog(10, 1'b0);
        chk("beq_taken_pc", {27'd0, imem_addr}, 32'd10);
        mem[1] = enc_i(6'd6, 5'd0, 5'd5, 16'd3);
        run_prog(10, 1'b0);
        chk("beq_not_taken_pc", {27'd0, imem_addr}, 32'd3);

        // A jump to 12, then NOPs that wrap pc from 31 to 0
        clear_mem();
        mem[5] = {6'd9, 26'd12};
        run_prog(30, 1'b0);
        do_reset();

        // Illegal opcode, then a restart that clears the flag
        clear_mem();
        mem[0] = {6'd17, 26'd0};
        run_prog(5, 1'b0);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        mem[0] = W_HALT;
        run_prog(5, 1'b0);

        // ADDI into r0 retires with no write
        clear_mem();
        rf[1] = 32'd7;
        mem[0] = enc_i(6'd6, 5'd1, 5'd0, 16'd5);
        mem[1] = W_HALT;
        run_prog(5, 1'b0);
        chk("r0_kept", rf[0], 32'd0);

        // Reset asserted during EXECUTE of an ADD
        do_reset();
        clear_mem();
        rf[1] = 32'd5;
        rf[2] = 32'd6;
        mem[0] = enc_r(6'd2, 5'd1, 5'd2, 5'd3);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_we_hold", {31'd0, rf_we}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_we", {31'd0, rf_we}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_addr", {27'd0, imem_addr}, 32'd0);
        end

        // Random programs
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] = (i == 0) ? 32'd0 :
                        ((i % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom());
                r   = $urandom_range(0, 19);
                rnd = $urandom();
                if (r == 19)      op = 6'd10 + 6'($urandom_range(0, 52));
                else if (r == 18) op = 6'd63;
                else              op = legal_ops[r % 9];
                mem[i] = {op, rnd[25:0]};
            end
            run_prog(25, (t % 4) == 0);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse: begin execution at address 0.
REQ-004 imem_addr  output  5  instruction memory address, equals pc.
REQ-005 imem_instr  input  32  combinational instruction memory data.
REQ-006 rf_ra1 / rf_ra2  output  5 each  register file read addresses, rs and rt.
REQ-007 rf_rd1 / rf_rd2  input  32 each  combinational register file read data.
REQ-008 rf_wa  output  5  write address.
REQ-009 rf_wd  output  32  write data.
REQ-010 rf_we  output  1  write enable, one-cycle pulse.
REQ-011 busy  output  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-012 halted  output  1  high in HALT.
REQ-013 illegal  output  1  sticky flag for an undefined opcode.
REQ-014 instr_count  output  16  count of retired instructions, wraps at 65535 -> 0.

Function
REQ-015 Instruction fields: op [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] zero-extended, target [25:0].
REQ-016 Opcode map:
- 0 NOP
- 2 ADD: rd=rs+rt
- 3 SUB: rd=rs-rt
- 4 AND: rd=rs&rt
- 5 OR: rd=rs|rt
- 6 ADDI: rt=rs+imm
- 7 SUBI: rt=rs-imm
- 8 BEQ
- 9 J
- 63 HALT
- any other opcode is illegal.
REQ-017 Arithmetic is 32-bit modulo 2^32; carry and borrow are discarded.
REQ-018 States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-019 IDLE: on start -> pc=0, instr_count=0, illegal=0, next state FETCH; without start, remain in IDLE.
REQ-020 FETCH: imem_addr=pc; IR latches imem_instr at end of cycle; -> DECODE.
REQ-021 DECODE: rf_ra1=IR.rs, rf_ra2=IR.rt; A and B latch rf_rd1 and rf_rd2; -> EXECUTE.
REQ-022 EXECUTE, ALU ops: result register latches ALU output; pc=pc+1; -> WRITEBACK.
REQ-023 EXECUTE, BEQ: if A==B, pc=pc+1+imm[4:0], else pc=pc+1; instr_count+1; -> FETCH.
REQ-024 EXECUTE, J: pc=target[4:0]; instr_count+1; -> FETCH.
REQ-025 EXECUTE, NOP: pc=pc+1; instr_count+1; -> FETCH.
REQ-026 EXECUTE, HALT: pc is unchanged; instr_count+1; -> HALT.
REQ-027 EXECUTE, illegal opcode: illegal=1; pc and instr_count are unchanged; -> HALT.
REQ-028 WRITEBACK: rf_wa=rd for R-type or rt for I-type; rf_wd=result; rf_we=1 unless the destination is register 0; instr_count+1; -> FETCH.
REQ-029 rf_we is 0 in every state other than WRITEBACK.
REQ-030 All pc arithmetic is 5-bit: 31+1 wraps to 0; branch and jump targets wrap modulo 32.
REQ-031 Latency: ALU instruction = 4 cycles; NOP, BEQ, J and HALT = 3 cycles each.
REQ-032 start is ignored while busy=1.
REQ-033 start while in HALT behaves exactly as start in IDLE.
REQ-034 rf_ra1, rf_ra2, rf_wa and rf_wd hold their last values when not in use; no glitch requirement applies.

Reset
REQ-035 While rst_n=0: state=IDLE; pc, IR, A, B and result = 0; rf_we=0; busy=0; halted=0; illegal=0; instr_count=0; imem_addr=0.
REQ-036 Reset asserted mid-instruction aborts the instruction immediately; no rf_we pulse follows.
REQ-037 After rst_n deasserts, the block remains in IDLE until start.

Verification
REQ-038 Program {ADDI r10=r0+10; ADDI r15=r0+15; ADD r25=r10+r15; HALT} with a zero-initialised register file, start -> three rf_we pulses with (10,10), (15,15), (25,25); halted=1; instr_count=4; pc=3; total of 15 cycles from FETCH of address 0 to HALT entry.
REQ-039 Program {ADDI r4=r0+4; ADDI r5=r0+4; BEQ r4,r5,+7 at addr 2} -> next fetch from address 10; with r5=3 instead, next fetch from address 3.
REQ-040 J with target=12 at address 5 -> next imem_addr=12; a word 0 at addresses 7-31 with no HALT -> pc wraps 31 -> 0.
REQ-041 Opcode 17 at address 0 -> illegal=1, halted=1, instr_count=0, no rf_we pulse; a subsequent start clears illegal and resumes fetch at address 0.
REQ-042 ADDI with destination r0 -> no rf_we pulse, instr_count increments; rst_n pulsed low during EXECUTE of ADD -> no rf_we pulse; outputs at reset values; state IDLE.
REQ-043 start pulsed in every cycle of a running program -> no restart; instruction sequence and instr_count identical to a single-start run.
